// File: rtl/dma_perf_monitor.sv
// Passive statistics collector for the DMA channel-0 AXI W/R data channels and
// the peripheral TX/RX request-to-clear latency. It only observes; it drives nothing back.

module dma_lat_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             req,
  input  logic             clr,
  output logic [CNT_W-1:0] req_cnt,
  output logic [CNT_W-1:0] lat_last,
  output logic [CNT_W-1:0] lat_max,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t           state;
  logic [CNT_W-1:0] lat;

  // HOLD absorbs a request level that stays high after its clear, so it is not recounted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      lat      <= '0;
      req_cnt  <= '0;
      lat_last <= '0;
      lat_max  <= '0;
      sat      <= 1'b0;
    end else if (clear) begin
      state    <= IDLE;
      lat      <= '0;
      req_cnt  <= '0;
      lat_last <= '0;
      lat_max  <= '0;
      sat      <= 1'b0;
    end else if (enable) begin
      case (state)
        IDLE: begin
          if (req) begin
            if (req_cnt != CNT_MAX) req_cnt <= req_cnt + CNT_ONE;
            if (req_cnt >= CNT_MAX - CNT_ONE) sat <= 1'b1;
            if (clr) begin
              lat_last <= '0;
              state    <= HOLD;
            end else begin
              lat   <= CNT_ONE;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (clr) begin
            lat_last <= lat;
            if (lat > lat_max) lat_max <= lat;
            state <= HOLD;
          end else begin
            if (lat != CNT_MAX) lat <= lat + CNT_ONE;
            if (lat >= CNT_MAX - CNT_ONE) sat <= 1'b1;
          end
        end
        HOLD: begin
          if (!req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

module dma_perf_monitor #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear,
  input  logic                periph_tx_req,
  input  logic                periph_tx_clr,
  input  logic                periph_rx_req,
  input  logic                periph_rx_clr,
  input  logic [DATA_W/8-1:0] WSTRB0,
  input  logic                WVALID0,
  input  logic                WREADY0,
  input  logic                RVALID0,
  input  logic                RREADY0,
  output logic [CNT_W-1:0]    wr_beats,
  output logic [CNT_W-1:0]    wr_bytes,
  output logic [CNT_W-1:0]    wr_stall,
  output logic [CNT_W-1:0]    rd_beats,
  output logic [CNT_W-1:0]    rd_stall,
  output logic [CNT_W-1:0]    tx_req_cnt,
  output logic [CNT_W-1:0]    rx_req_cnt,
  output logic [CNT_W-1:0]    tx_lat_last,
  output logic [CNT_W-1:0]    rx_lat_last,
  output logic [CNT_W-1:0]    tx_lat_max,
  output logic [CNT_W-1:0]    rx_lat_max,
  output logic                sat
);

  localparam int               STRB_W  = DATA_W / 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] popcount(input logic [STRB_W-1:0] s);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < STRB_W; i++) n = n + CNT_W'(s[i]);
    return n;
  endfunction

  // The carry-out of the widened sum marks overflow; clamp there instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  logic [CNT_W-1:0] wr_beats_nx, wr_bytes_nx, wr_stall_nx, rd_beats_nx, rd_stall_nx;
  logic             cnt_hit;
  logic             cnt_sat;
  logic             tx_sat, rx_sat;

  always_comb begin
    wr_beats_nx = wr_beats;
    wr_bytes_nx = wr_bytes;
    wr_stall_nx = wr_stall;
    rd_beats_nx = rd_beats;
    rd_stall_nx = rd_stall;
    if (WVALID0 && WREADY0) begin
      wr_beats_nx = sat_add(wr_beats, CNT_ONE);
      wr_bytes_nx = sat_add(wr_bytes, popcount(WSTRB0));
    end
    if (WVALID0 && !WREADY0) wr_stall_nx = sat_add(wr_stall, CNT_ONE);
    if (RVALID0 && RREADY0)  rd_beats_nx = sat_add(rd_beats, CNT_ONE);
    if (RVALID0 && !RREADY0) rd_stall_nx = sat_add(rd_stall, CNT_ONE);
    cnt_hit = (wr_beats_nx == CNT_MAX) || (wr_bytes_nx == CNT_MAX) ||
              (wr_stall_nx == CNT_MAX) || (rd_beats_nx == CNT_MAX) ||
              (rd_stall_nx == CNT_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_beats <= '0;
      wr_bytes <= '0;
      wr_stall <= '0;
      rd_beats <= '0;
      rd_stall <= '0;
      cnt_sat  <= 1'b0;
    end else if (clear) begin
      wr_beats <= '0;
      wr_bytes <= '0;
      wr_stall <= '0;
      rd_beats <= '0;
      rd_stall <= '0;
      cnt_sat  <= 1'b0;
    end else if (enable) begin
      wr_beats <= wr_beats_nx;
      wr_bytes <= wr_bytes_nx;
      wr_stall <= wr_stall_nx;
      rd_beats <= rd_beats_nx;
      rd_stall <= rd_stall_nx;
      if (cnt_hit) cnt_sat <= 1'b1;
    end
  end

  dma_lat_fsm #(.CNT_W(CNT_W)) u_tx_lat (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .clear    (clear),
    .req      (periph_tx_req),
    .clr      (periph_tx_clr),
    .req_cnt  (tx_req_cnt),
    .lat_last (tx_lat_last),
    .lat_max  (tx_lat_max),
    .sat      (tx_sat)
  );

  dma_lat_fsm #(.CNT_W(CNT_W)) u_rx_lat (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .clear    (clear),
    .req      (periph_rx_req),
    .clr      (periph_rx_clr),
    .req_cnt  (rx_req_cnt),
    .lat_last (rx_lat_last),
    .lat_max  (rx_lat_max),
    .sat      (rx_sat)
  );

  // Each sticky flag is its own register, so the combined flag is still glitch-free.
  assign sat = cnt_sat | tx_sat | rx_sat;

endmodule

// File: tb/tb_dma_perf_monitor.sv
// Scoreboard bench for dma_perf_monitor: a full-width and a 4-bit-counter instance
// share stimulus and are compared every cycle against a reference model.

module tb_dma_perf_monitor;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic clear = 1'b0;
  logic periph_tx_req = 1'b0, periph_tx_clr = 1'b0;
  logic periph_rx_req = 1'b0, periph_rx_clr = 1'b0;
  logic [7:0] WSTRB0 = '0;
  logic WVALID0 = 1'b0, WREADY0 = 1'b0, RVALID0 = 1'b0, RREADY0 = 1'b0;

  logic [31:0] b_wr_beats, b_wr_bytes, b_wr_stall, b_rd_beats, b_rd_stall;
  logic [31:0] b_tx_req_cnt, b_rx_req_cnt, b_tx_lat_last, b_rx_lat_last;
  logic [31:0] b_tx_lat_max, b_rx_lat_max;
  logic        b_sat;
  logic [3:0]  s_wr_beats, s_wr_bytes, s_wr_stall, s_rd_beats, s_rd_stall;
  logic [3:0]  s_tx_req_cnt, s_rx_req_cnt, s_tx_lat_last, s_rx_lat_last;
  logic [3:0]  s_tx_lat_max, s_rx_lat_max;
  logic        s_sat;

  always #5 clk = ~clk;

  dma_perf_monitor #(.DATA_W(64), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .periph_tx_req(periph_tx_req), .periph_tx_clr(periph_tx_clr),
    .periph_rx_req(periph_rx_req), .periph_rx_clr(periph_rx_clr),
    .WSTRB0(WSTRB0), .WVALID0(WVALID0), .WREADY0(WREADY0),
    .RVALID0(RVALID0), .RREADY0(RREADY0),
    .wr_beats(b_wr_beats), .wr_bytes(b_wr_bytes), .wr_stall(b_wr_stall),
    .rd_beats(b_rd_beats), .rd_stall(b_rd_stall),
    .tx_req_cnt(b_tx_req_cnt), .rx_req_cnt(b_rx_req_cnt),
    .tx_lat_last(b_tx_lat_last), .rx_lat_last(b_rx_lat_last),
    .tx_lat_max(b_tx_lat_max), .rx_lat_max(b_rx_lat_max), .sat(b_sat)
  );

  dma_perf_monitor #(.DATA_W(64), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .periph_tx_req(periph_tx_req), .periph_tx_clr(periph_tx_clr),
    .periph_rx_req(periph_rx_req), .periph_rx_clr(periph_rx_clr),
    .WSTRB0(WSTRB0), .WVALID0(WVALID0), .WREADY0(WREADY0),
    .RVALID0(RVALID0), .RREADY0(RREADY0),
    .wr_beats(s_wr_beats), .wr_bytes(s_wr_bytes), .wr_stall(s_wr_stall),
    .rd_beats(s_rd_beats), .rd_stall(s_rd_stall),
    .tx_req_cnt(s_tx_req_cnt), .rx_req_cnt(s_rx_req_cnt),
    .tx_lat_last(s_tx_lat_last), .rx_lat_last(s_rx_lat_last),
    .tx_lat_max(s_tx_lat_max), .rx_lat_max(s_rx_lat_max), .sat(s_sat)
  );

  typedef struct packed {
    logic [31:0] wr_beats, wr_bytes, wr_stall, rd_beats, rd_stall;
    logic [31:0] tx_req_cnt, rx_req_cnt, tx_lat_last, rx_lat_last;
    logic [31:0] tx_lat_max, rx_lat_max;
    logic        sat;
  } snap_t;

  snap_t q0[$];
  snap_t q1[$];
  int assertions = 0;
  int failures = 0;

  // Reference model, index [instance][direction]; directions 0 = TX, 1 = RX.
  longint mx[2];
  longint cnt[2][5];
  longint reqc[2][2], llast[2][2], lmax[2][2], lcur[2][2];
  bit     measuring[2][2], waitDrop[2][2];
  bit     satf[2];

  function automatic longint sadd(input longint a, input longint b, input longint m);
    return (a + b > m) ? m : a + b;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 5; i++) cnt[k][i] = 0;
      for (int d = 0; d < 2; d++) begin
        reqc[k][d] = 0; llast[k][d] = 0; lmax[k][d] = 0; lcur[k][d] = 0;
        measuring[k][d] = 0; waitDrop[k][d] = 0;
      end
      satf[k] = 0;
    end
  endtask

  task automatic latStep(input int k, input int d, input bit req, input bit clr);
    if (waitDrop[k][d]) begin
      if (!req) waitDrop[k][d] = 0;
    end else if (measuring[k][d]) begin
      if (clr) begin
        llast[k][d] = lcur[k][d];
        if (lcur[k][d] > lmax[k][d]) lmax[k][d] = lcur[k][d];
        measuring[k][d] = 0;
        waitDrop[k][d] = 1;
      end else begin
        lcur[k][d] = sadd(lcur[k][d], 1, mx[k]);
      end
    end else if (req) begin
      reqc[k][d] = sadd(reqc[k][d], 1, mx[k]);
      if (clr) begin
        llast[k][d] = 0;
        waitDrop[k][d] = 1;
      end else begin
        lcur[k][d] = 1;
        measuring[k][d] = 1;
      end
    end
  endtask

  task automatic modelStep(input bit en, input bit clr, input bit tq, input bit tc,
                           input bit rq, input bit rc, input logic [7:0] strb,
                           input bit wv, input bit wr, input bit rv, input bit rr);
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        for (int i = 0; i < 5; i++) cnt[k][i] = 0;
        for (int d = 0; d < 2; d++) begin
          reqc[k][d] = 0; llast[k][d] = 0; lmax[k][d] = 0; lcur[k][d] = 0;
          measuring[k][d] = 0; waitDrop[k][d] = 0;
        end
        satf[k] = 0;
      end else if (en) begin
        if (wv && wr) begin
          cnt[k][0] = sadd(cnt[k][0], 1, mx[k]);
          cnt[k][1] = sadd(cnt[k][1], $countones(strb), mx[k]);
        end
        if (wv && !wr) cnt[k][2] = sadd(cnt[k][2], 1, mx[k]);
        if (rv && rr)  cnt[k][3] = sadd(cnt[k][3], 1, mx[k]);
        if (rv && !rr) cnt[k][4] = sadd(cnt[k][4], 1, mx[k]);
        latStep(k, 0, tq, tc);
        latStep(k, 1, rq, rc);
        for (int i = 0; i < 5; i++) if (cnt[k][i] == mx[k]) satf[k] = 1;
        for (int d = 0; d < 2; d++)
          if (reqc[k][d] == mx[k] || lcur[k][d] == mx[k]) satf[k] = 1;
      end
    end
  endtask

  function automatic snap_t modelSnap(input int k);
    snap_t s;
    s.wr_beats = 32'(cnt[k][0]);     s.wr_bytes = 32'(cnt[k][1]);
    s.wr_stall = 32'(cnt[k][2]);     s.rd_beats = 32'(cnt[k][3]);
    s.rd_stall = 32'(cnt[k][4]);
    s.tx_req_cnt = 32'(reqc[k][0]);  s.rx_req_cnt = 32'(reqc[k][1]);
    s.tx_lat_last = 32'(llast[k][0]); s.rx_lat_last = 32'(llast[k][1]);
    s.tx_lat_max = 32'(lmax[k][0]);  s.rx_lat_max = 32'(lmax[k][1]);
    s.sat = satf[k];
    return s;
  endfunction

  function automatic snap_t bigSnap();
    snap_t s;
    s.wr_beats = b_wr_beats; s.wr_bytes = b_wr_bytes; s.wr_stall = b_wr_stall;
    s.rd_beats = b_rd_beats; s.rd_stall = b_rd_stall;
    s.tx_req_cnt = b_tx_req_cnt; s.rx_req_cnt = b_rx_req_cnt;
    s.tx_lat_last = b_tx_lat_last; s.rx_lat_last = b_rx_lat_last;
    s.tx_lat_max = b_tx_lat_max; s.rx_lat_max = b_rx_lat_max;
    s.sat = b_sat;
    return s;
  endfunction

  function automatic snap_t smallSnap();
    snap_t s;
    s.wr_beats = 32'(s_wr_beats); s.wr_bytes = 32'(s_wr_bytes); s.wr_stall = 32'(s_wr_stall);
    s.rd_beats = 32'(s_rd_beats); s.rd_stall = 32'(s_rd_stall);
    s.tx_req_cnt = 32'(s_tx_req_cnt); s.rx_req_cnt = 32'(s_rx_req_cnt);
    s.tx_lat_last = 32'(s_tx_lat_last); s.rx_lat_last = 32'(s_rx_lat_last);
    s.tx_lat_max = 32'(s_tx_lat_max); s.rx_lat_max = 32'(s_rx_lat_max);
    s.sat = s_sat;
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compareSnap(input string tag, input snap_t a, input snap_t e);
    checkOutput({tag, ".wr_beats"}, 64'(a.wr_beats), 64'(e.wr_beats));
    checkOutput({tag, ".wr_bytes"}, 64'(a.wr_bytes), 64'(e.wr_bytes));
    checkOutput({tag, ".wr_stall"}, 64'(a.wr_stall), 64'(e.wr_stall));
    checkOutput({tag, ".rd_beats"}, 64'(a.rd_beats), 64'(e.rd_beats));
    checkOutput({tag, ".rd_stall"}, 64'(a.rd_stall), 64'(e.rd_stall));
    checkOutput({tag, ".tx_req_cnt"}, 64'(a.tx_req_cnt), 64'(e.tx_req_cnt));
    checkOutput({tag, ".rx_req_cnt"}, 64'(a.rx_req_cnt), 64'(e.rx_req_cnt));
    checkOutput({tag, ".tx_lat_last"}, 64'(a.tx_lat_last), 64'(e.tx_lat_last));
    checkOutput({tag, ".rx_lat_last"}, 64'(a.rx_lat_last), 64'(e.rx_lat_last));
    checkOutput({tag, ".tx_lat_max"}, 64'(a.tx_lat_max), 64'(e.tx_lat_max));
    checkOutput({tag, ".rx_lat_max"}, 64'(a.rx_lat_max), 64'(e.rx_lat_max));
    checkOutput({tag, ".sat"}, 64'(a.sat), 64'(e.sat));
  endtask

  // Monitor: one expected snapshot is consumed per clock edge or reset assertion.
  initial begin
    forever begin
      @(posedge clk or posedge reset);
      #1;
      if (q0.size() > 0) compareSnap("big", bigSnap(), q0.pop_front());
      if (q1.size() > 0) compareSnap("small", smallSnap(), q1.pop_front());
    end
  end

  task automatic applyStimulus(input bit en, input bit clr, input bit tq, input bit tc,
                               input bit rq, input bit rc, input logic [7:0] strb,
                               input bit wv, input bit wr, input bit rv, input bit rr);
    @(negedge clk);
    enable = en; clear = clr;
    periph_tx_req = tq; periph_tx_clr = tc; periph_rx_req = rq; periph_rx_clr = rc;
    WSTRB0 = strb; WVALID0 = wv; WREADY0 = wr; RVALID0 = rv; RREADY0 = rr;
    modelStep(en, clr, tq, tc, rq, rc, strb, wv, wr, rv, rr);
    q0.push_back(modelSnap(0));
    q1.push_back(modelSnap(1));
  endtask

  task automatic doReset(input bit checkNow);
    @(negedge clk);
    #2;
    modelReset();
    q0.push_back(modelSnap(0));
    q1.push_back(modelSnap(1));
    reset = 1'b1;
    enable = 1'b0; clear = 1'b0;
    periph_tx_req = 1'b0; periph_tx_clr = 1'b0; periph_rx_req = 1'b0; periph_rx_clr = 1'b0;
    WVALID0 = 1'b0; WREADY0 = 1'b0; RVALID0 = 1'b0; RREADY0 = 1'b0; WSTRB0 = '0;
    if (checkNow) begin
      #1;
      checkOutput("async_reset.tx_req_cnt", 64'(b_tx_req_cnt), 64'd0);
      checkOutput("async_reset.wr_beats", 64'(b_wr_beats), 64'd0);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit tq, rq;
    mx[0] = 64'hFFFF_FFFF;
    mx[1] = 15;
    modelReset();
    doReset(1'b0);

    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0, 0, 0, 8'hFF, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++)  applyStimulus(1, 0, 0, 0, 0, 0, 8'h0F, 1, 1, 0, 0);
    for (int i = 0; i < 2; i++)  applyStimulus(1, 0, 0, 0, 0, 0, 8'hFF, 1, 0, 0, 0);
    settle();
    checkOutput("w.wr_beats", 64'(b_wr_beats), 64'd13);
    checkOutput("w.wr_bytes", 64'(b_wr_bytes), 64'd92);
    checkOutput("w.wr_stall", 64'(b_wr_stall), 64'd2);
    checkOutput("w.rd_beats", 64'(b_rd_beats), 64'd0);

    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1, (i % 2) == 0);
    settle();
    checkOutput("r.rd_beats", 64'(b_rd_beats), 64'd4);
    checkOutput("r.rd_stall", 64'(b_rd_stall), 64'd4);

    for (int c = 0; c < 16; c++)
      applyStimulus(1, 0, (c >= 5 && c <= 14), (c == 12), 0, 0, 8'h00, 0, 0, 0, 0);
    settle();
    checkOutput("tx1.lat_last", 64'(b_tx_lat_last), 64'd7);
    for (int c = 0; c < 4; c++) applyStimulus(1, 0, 1, (c == 3), 0, 0, 8'h00, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    settle();
    checkOutput("tx2.req_cnt", 64'(b_tx_req_cnt), 64'd2);
    checkOutput("tx2.lat_last", 64'(b_tx_lat_last), 64'd3);
    checkOutput("tx2.lat_max", 64'(b_tx_lat_max), 64'd7);

    applyStimulus(1, 0, 0, 0, 1, 1, 8'h00, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    settle();
    checkOutput("rx0.req_cnt", 64'(b_rx_req_cnt), 64'd1);
    checkOutput("rx0.lat_last", 64'(b_rx_lat_last), 64'd0);
    checkOutput("rx0.lat_max", 64'(b_rx_lat_max), 64'd0);

    applyStimulus(1, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 0, 0, 8'hFF, 1, 1, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    applyStimulus(1, 0, 1, 1, 0, 0, 8'h00, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    settle();
    checkOutput("freeze.wr_beats", 64'(b_wr_beats), 64'd13);
    checkOutput("freeze.tx_lat_last", 64'(b_tx_lat_last), 64'd4);
    checkOutput("freeze.tx_req_cnt", 64'(b_tx_req_cnt), 64'd3);

    applyStimulus(0, 1, 0, 0, 0, 0, 8'hFF, 1, 1, 1, 1);
    settle();
    checkOutput("clear.tx_lat_max", 64'(b_tx_lat_max), 64'd0);
    checkOutput("clear.small_sat", 64'(s_sat), 64'd0);

    for (int i = 0; i < 17; i++) applyStimulus(1, 0, 0, 0, 0, 0, 8'h01, 1, 1, 0, 0);
    settle();
    checkOutput("sat.small_wr_beats", 64'(s_wr_beats), 64'd15);
    checkOutput("sat.small_sat", 64'(s_sat), 64'd1);
    checkOutput("sat.big_wr_beats", 64'(b_wr_beats), 64'd17);
    checkOutput("sat.big_sat", 64'(b_sat), 64'd0);

    for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0, 0);
    doReset(1'b1);

    tq = 0;
    rq = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(5) == 0) tq = ~tq;
      if ($urandom_range(5) == 0) rq = ~rq;
      applyStimulus($urandom_range(7) != 0, $urandom_range(63) == 0,
                    tq, $urandom_range(4) == 0, rq, $urandom_range(4) == 0,
                    8'($urandom), $urandom_range(1) == 1, $urandom_range(1) == 1,
                    $urandom_range(1) == 1, $urandom_range(1) == 1);
    end

    repeat (3) settle();
    checkOutput("scoreboard_drain", 64'(q0.size() + q1.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
